// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and default widths for the cache<->memory interface.
//   state_e   : responder FSM states (IDLE, WAIT, XFER)
//   MRW_READ / MRW_WRITE : encodings of the MRW request direction bit
//   MEM_*     : default widths, shared with the cache controller
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_e;

    localparam logic MRW_READ  = 1'b1;
    localparam logic MRW_WRITE = 1'b0;

    localparam int unsigned MEM_ADDR_W         = 16;
    localparam int unsigned MEM_DATA_W         = 32;
    localparam int unsigned MEM_WORDS_PER_LINE = 4;
    localparam int unsigned MEM_LATENCY        = 4;
    localparam int unsigned MEM_DEPTH          = 1024;

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH x DATA_W word storage. Not reset.
//   clk   in  : write clock
//   we    in  : write enable, write occurs at rising edge
//   addr  in  : word address, shared by read and write
//   wdata in  : write data
//   rdata out : asynchronous read data at addr
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Main-memory end of the cache<->memory interface. Accepts a line request,
// waits a fixed latency, then transfers one line as WORDS_PER_LINE beats.
//   clk      in  : clock, all state on rising edge
//   reset    in  : synchronous, active-high
//   MStrobe  in  : request valid, sampled only in IDLE
//   MRW      in  : 1 = read line, 0 = write line
//   MAddr    in  : word address of request (taken modulo DEPTH)
//   MDataIn  in  : write data, sampled on each write beat
//   MDataOut out : read data on read beats, else 0
//   MReady   out : one strobe per beat
//   MBusy    out : high while not IDLE
// Build option: MEMRESP_CRITWORD_EN defined -> burst starts at the requested
// word and wraps within the line; undefined -> burst always starts at the
// line base.
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned WORDS_PER_LINE = MEM_WORDS_PER_LINE,
    parameter int unsigned LATENCY        = MEM_LATENCY,
    parameter int unsigned DEPTH          = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(WORDS_PER_LINE);
    localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT counts down from LATENCY-2 to 0 inclusive: LATENCY-1 cycles.
    localparam int unsigned LAT_LOAD = (LATENCY >= 2) ? LATENCY - 2 : 0;

    state_e          state_q, state_d;
    logic            rw_q, rw_d;
    logic [AW-1:OW]  base_q, base_d;
    logic [OW-1:0]   off_q, off_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [OW-1:0]   beat_q, beat_d;

    logic [OW-1:0]     start_off;
    logic [OW-1:0]     lane;
    logic [AW-1:0]     word_idx;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              addr_unused;

`ifdef MEMRESP_CRITWORD_EN
    assign start_off = MAddr[OW-1:0];
`else
    assign start_off = '0;
`endif

    // Bits above AW are discarded by the modulo-DEPTH wrap.
    assign addr_unused = ^MAddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rw_q    <= MRW_READ;
            base_q  <= '0;
            off_q   <= '0;
            lat_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            base_q  <= base_d;
            off_q   <= off_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        base_d  = base_q;
        off_d   = off_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (MStrobe) begin
                    rw_d    = MRW;
                    base_d  = MAddr[AW-1:OW];
                    off_d   = start_off;
                    lat_d   = LW'(LAT_LOAD);
                    state_d = (LATENCY == 1) ? XFER : WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = XFER;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            XFER: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane arithmetic is OW bits wide so the burst wraps inside the line.
    assign lane     = off_q + beat_q;
    assign word_idx = {base_q, lane};

    // A beat coinciding with reset is dropped rather than committed.
    assign mem_we = (state_q == XFER) && (rw_q == MRW_WRITE) && !reset;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (MDataIn),
        .rdata (mem_rdata)
    );

    assign MReady   = (state_q == XFER);
    assign MBusy    = (state_q != IDLE);
    assign MDataOut = ((state_q == XFER) && (rw_q == MRW_READ)) ? mem_rdata : '0;

endmodule
